// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: FP32 field layout, FP constants,
// accumulator state encoding and the default neuron address width.
package neuron_pkg;

    // FP32 field positions
    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_MSB  = 30;
    localparam int unsigned FP_EXP_LSB  = 23;
    localparam int unsigned FP_MAN_MSB  = 22;

    localparam logic [31:0] FP_POS_ZERO   = 32'h0000_0000;
    // Largest finite magnitude; the sign is supplied separately
    localparam logic [30:0] FP_MAX_FINITE = 31'h7F7F_FFFF;

    localparam int unsigned ADDR_W_DEFAULT = 12;

    typedef enum logic {
        StIdle,
        StAccum
    } state_e;

    // Leading-zero count of the 27-bit normalisation window
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_adder.sv
// Combinational FP32 adder: round toward zero, denormals flushed to +0,
// overflow saturates to the largest finite value, inf/NaN passes operand a.
module fp32_adder
    import neuron_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        exception
);

    logic [7:0]        ea, eb, big_e, small_e, diff;
    logic [23:0]       ma, mb, big_m, small_m;
    logic              big_s, eff_sub;
    logic [26:0]       big_ext, small_ext, shifted, lost;
    logic              sticky;
    logic [27:0]       raw;
    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] exp_r;
    logic              unused_norm;

    // Unpack, flush denormals, order operands by magnitude and align the smaller one
    always_comb begin
        ea = a[FP_EXP_MSB:FP_EXP_LSB];
        eb = b[FP_EXP_MSB:FP_EXP_LSB];
        ma = (ea != 8'd0) ? {1'b1, a[FP_MAN_MSB:0]} : 24'd0;
        mb = (eb != 8'd0) ? {1'b1, b[FP_MAN_MSB:0]} : 24'd0;
        eff_sub = a[FP_SIGN_BIT] ^ b[FP_SIGN_BIT];
        if ({ea, ma} >= {eb, mb}) begin
            big_e   = ea;
            big_m   = ma;
            big_s   = a[FP_SIGN_BIT];
            small_e = eb;
            small_m = mb;
        end else begin
            big_e   = eb;
            big_m   = mb;
            big_s   = b[FP_SIGN_BIT];
            small_e = ea;
            small_m = ma;
        end
        diff      = big_e - small_e;
        // Three guard bits (G, R, sticky) make truncation of the exact result correct
        big_ext   = {big_m, 3'b000};
        small_ext = {small_m, 3'b000};
        shifted   = small_ext >> diff;
        lost      = small_ext & ~({27{1'b1}} << diff);
        sticky    = |lost;
        raw = eff_sub ? ({1'b0, big_ext} - {1'b0, shifted | {26'd0, sticky}})
                      : ({1'b0, big_ext} + {1'b0, shifted | {26'd0, sticky}});
    end

    // Normalise: one right shift on carry-out, otherwise left shift by leading zeros
    always_comb begin
        lz = 5'd0;
        if (raw[27]) begin
            norm  = raw[27:1] | {26'd0, raw[0]};
            exp_r = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
            lz    = clz27(raw[26:0]);
            norm  = raw[26:0] << lz;
            exp_r = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
        end
    end

    // Pack with special cases; the low guard bits are simply dropped (truncation)
    always_comb begin
        exception = 1'b0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            sum       = a;
            exception = 1'b1;
        end else if (raw == 28'd0) begin
            sum = FP_POS_ZERO;
        end else if (exp_r >= 10'sd255) begin
            sum       = {big_s, FP_MAX_FINITE};
            exception = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            sum = FP_POS_ZERO;
        end else begin
            sum = {big_s, exp_r[7:0], norm[25:3]};
        end
    end

    assign unused_norm = ^{norm[26], norm[2:0]};

endmodule

// File: rtl/potential_adder.sv
// Accumulates a stream of FP32 synaptic weights onto one neuron's membrane
// potential and emits the sum with a one-cycle valid pulse.
// Optional build macro POTENTIAL_ADDER_CLAMP_EN: negative final sums are emitted as +0.
module potential_adder
    import neuron_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_SPIKES = 16,
    localparam int unsigned CNT_W     = $clog2(MAX_SPIKES) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] neuron_address_in,
    input  logic [DATA_W-1:0] membrane_potential_in,
    input  logic              clear,
    input  logic              weight_valid,
    output logic              weight_ready,
    input  logic [DATA_W-1:0] weight,
    input  logic              weight_last,
    output logic [DATA_W-1:0] new_potential,
    output logic              new_potential_valid,
    output logic [ADDR_W-1:0] neuron_address_out,
    output logic [CNT_W-1:0]  spike_count,
    output logic              exception
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d, count_inc;
    logic                exc_q, exc_d;
    logic [DATA_W-1:0]   new_pot_q, new_pot_d;
    logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
    logic [CNT_W-1:0]    spike_cnt_q, spike_cnt_d;
    logic                valid_q, valid_d;
    logic                handshake, finalise;
    logic [DATA_W-1:0]   add_sum;
    logic                add_exc;

    fp32_adder u_fp32_adder (
        .a         (acc_q),
        .b         (weight),
        .sum       (add_sum),
        .exception (add_exc)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start)    state_d = StAccum;
            StAccum: if (finalise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        weight_ready = (state_q == StAccum);
    end

    // Beat acceptance and finalisation conditions
    always_comb begin
        handshake = weight_valid & weight_ready;
        count_inc = count_q + CNT_W'(1);
        finalise  = (state_q == StAccum) &
                    ((handshake & (weight_last | (count_inc == CNT_W'(MAX_SPIKES)))) | clear);
    end

    // Datapath next state: load on start, accumulate on beats, publish on finalise
    always_comb begin
        acc_d       = acc_q;
        addr_d      = addr_q;
        count_d     = count_q;
        exc_d       = exc_q;
        new_pot_d   = new_pot_q;
        addr_out_d  = addr_out_q;
        spike_cnt_d = spike_cnt_q;
        valid_d     = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                acc_d   = membrane_potential_in;
                addr_d  = neuron_address_in;
                count_d = '0;
                exc_d   = 1'b0;
            end
        end else begin
            if (handshake) begin
                acc_d   = add_sum;
                count_d = count_inc;
                exc_d   = exc_q | add_exc;
            end
            // A same-cycle beat is already folded into acc_d/count_d here
            if (finalise) begin
`ifdef POTENTIAL_ADDER_CLAMP_EN
                new_pot_d = acc_d[DATA_W-1] ? FP_POS_ZERO : acc_d;
`else
                new_pot_d = acc_d;
`endif
                addr_out_d  = addr_q;
                spike_cnt_d = count_d;
                valid_d     = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q       <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            exc_q       <= 1'b0;
            new_pot_q   <= '0;
            addr_out_q  <= '0;
            spike_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            exc_q       <= exc_d;
            new_pot_q   <= new_pot_d;
            addr_out_q  <= addr_out_d;
            spike_cnt_q <= spike_cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign new_potential       = new_pot_q;
    assign new_potential_valid = valid_q;
    assign neuron_address_out  = addr_out_q;
    assign spike_count         = spike_cnt_q;
    assign exception           = exc_q;

endmodule

// File: doc/potential_adder.md
Name: potential_adder

Overview:
Stage directly upstream of the potential decay stage. For one neuron per timestep, accumulates a stream of FP32 synaptic weights onto that neuron's membrane potential and emits the summed potential (new_potential) with a one-cycle valid pulse. The decay stage consumes new_potential. Processes one weight per cycle over a valid/ready handshake.

Parameters:
ADDR_W, 12, neuron address width
DATA_W, 32, IEEE-754 single-precision word width (fixed at 32; the parameter exists for documentation only)
MAX_SPIKES, 16, maximum weights accepted per accumulation; the counter is clog2(MAX_SPIKES)+1 bits wide

Ports:
CLK  in  1  clock, all logic on the rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  begin accumulation; sampled only in IDLE
neuron_address_in  in  ADDR_W  neuron address, latched on start
membrane_potential_in  in  32  initial potential, latched on start
clear  in  1  timestep end; forces finalisation while in ACCUM
weight_valid  in  1  weight beat valid
weight_ready  out  1  high only in ACCUM
weight  in  32  FP32 synaptic weight
weight_last  in  1  marks the final weight of this neuron
new_potential  out  32  accumulated potential (registered)
new_potential_valid  out  1  one-cycle pulse
neuron_address_out  out  ADDR_W  address associated with new_potential
spike_count  out  clog2(MAX_SPIKES)+1  number of weights accepted in the finished accumulation
exception  out  1  sticky FP exception; cleared on start

Behaviour:
- Reset (synchronous, active-high): state=IDLE; every output = 0; internal accumulator and counter = 0. Reset overrides all other inputs, including mid-ACCUM. Partial sums are discarded and no valid pulse is emitted.
- States:
  - IDLE: weight_ready=0. On start: acc<=membrane_potential_in, addr<=neuron_address_in, count<=0, exception<=0, go to ACCUM.
  - ACCUM: weight_ready=1. A handshake (weight_valid & weight_ready) sets acc<=fp_add(acc,weight) and count<=count+1, one beat per cycle.
- Finalise: taken in ACCUM on the first edge where any of these holds:
  - handshake with weight_last=1;
  - handshake making count==MAX_SPIKES;
  - clear=1.
- On that edge: new_potential<=final sum (includes any same-cycle beat), neuron_address_out<=addr, spike_count<=final count, new_potential_valid<=1, state<=IDLE. The valid pulse is therefore high exactly the cycle after the finalising edge. new_potential, neuron_address_out and spike_count hold their values until the next finalisation.
- Simultaneous clear and handshake: the beat is accumulated, then finalised.
- clear with no handshake and count=0: emits the latched potential unchanged, spike_count=0.
- start in ACCUM: ignored. clear in IDLE: ignored. start is ignored in the pulse cycle only if the state is not IDLE; IDLE is re-entered on the finalising edge, so back-to-back start is legal.
- fp_add rules:
  - IEEE-754 single precision, round toward zero (truncate).
  - Denormal inputs and outputs flush to +0; an exact zero result is +0.
  - Exponent overflow: result saturates to ±0x7F7FFFFF and exception<=1.
  - Either operand with exponent 255 (inf/NaN): acc unchanged and exception<=1.
- exception is sticky until the next start.

Optional Feature:
POTENTIAL_ADDER_CLAMP_EN:
- Defined: if the final sum is negative (sign bit 1), new_potential is emitted as 0x00000000. The internal accumulator is unaffected during accumulation.
- Undefined: the signed sum is emitted as computed.

Decomposition:
- Shared package neuron_pkg:
  - FP32 field widths and positions (sign 31, exponent 30:23, mantissa 22:0);
  - constants FP_POS_ZERO=32'h0, FP_MAX_FINITE=31'h7F7FFFFF (magnitude);
  - state encoding IDLE/ACCUM;
  - ADDR_W default.
- One sub-module, fp32_adder (combinational): inputs a, b; outputs sum, exception. Contains alignment, add/sub, normalisation, truncation, flush-to-zero and saturation. The FSM, counter and output registers stay in potential_adder.

Test Plan:
- start with potential 0x3F800000 (1.0); weights 0x3F000000 (0.5), then 0x40000000 (2.0, last) on consecutive cycles -> new_potential=0x40600000 (3.5), valid pulse for 1 cycle immediately after the last beat, spike_count=2.
- potential 1.0; weight 0xC0400000 (-3.0, last) -> new_potential=0xC0000000 (-2.0); with POTENTIAL_ADDER_CLAMP_EN -> 0x00000000.
- potential 1.0; weight 0.5 without last, then clear=1 with no beat -> new_potential=0x3FC00000 (1.5), spike_count=1. Repeat with clear and a 0.5 beat in the same cycle -> 0x40000000.
- MAX_SPIKES=4, potential 0; five 1.0 weights offered, none with last -> finalise after the 4th beat: new_potential=0x40800000, spike_count=4; weight_ready=0 while the 5th is offered.
- potential 0x7F7FFFFF; weight 0x7F7FFFFF (last) -> new_potential=0x7F7FFFFF, exception=1; the next start clears exception to 0.
- RESET asserted during ACCUM after 2 beats -> next cycle all outputs 0, weight_ready=0, no valid pulse; a following start/accumulation behaves normally.
